// File: rtl/core_pkg.sv
// Shared types and constants for the TOY core front end.
package core_pkg;

  localparam logic [7:0] CORE_RESET_PC = 8'h10;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } ifq_entry_t;

endpackage

// File: rtl/core_ifq_storage.sv
// Fetch queue entry array: one write port, one asynchronous read port.
module core_ifq_storage
  import core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  ifq_entry_t    wdata_i,
  input  logic [AW-1:0] raddr_i,
  output ifq_entry_t    rdata_o
);

  ifq_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/core_ifq.sv
// Instruction fetch queue between imem and the dx stage.
// Define CORE_IFQ_BYPASS_EN to forward memory data to dx when empty.
module core_ifq
  import core_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter logic [7:0] RESET_PC = CORE_RESET_PC,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          exec_i,
  input  logic          flush_i,
  input  logic [7:0]    flush_pc_i,
  output logic          mem_val_o,
  output logic [7:0]    mem_addr_o,
  input  logic          mem_rdy_i,
  input  logic [15:0]   mem_data_i,
  output logic          out_val_o,
  input  logic          out_rdy_i,
  output logic [7:0]    out_pc_o,
  output logic [15:0]   out_instr_o,
  output logic [CW-1:0] count_o
);

  logic [7:0]    fetch_pc_q, fetch_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic       empty, full;
  logic       push, pop, byp, wr_en;
  ifq_entry_t head, wdata;

  assign empty = (count_q == '0);
  assign full  = (count_q == CW'(DEPTH));

  // No pop credit: a full queue stays closed even if dx pops now.
  assign mem_val_o  = ~arst_i & exec_i & ~flush_i & ~full;
  assign mem_addr_o = fetch_pc_q;
  assign push       = mem_val_o & mem_rdy_i;

`ifdef CORE_IFQ_BYPASS_EN
  assign byp   = empty & push;
  assign wr_en = push & ~(byp & out_rdy_i);
`else
  assign byp   = 1'b0;
  assign wr_en = push;
`endif

  assign out_val_o = (~empty | byp) & ~flush_i;
  assign pop       = out_val_o & out_rdy_i & ~empty;

  always_comb begin
    out_pc_o    = '0;
    out_instr_o = '0;
    if (byp) begin
      out_pc_o    = fetch_pc_q;
      out_instr_o = mem_data_i;
    end else if (!empty) begin
      out_pc_o    = head.pc;
      out_instr_o = head.instr;
    end
  end

  assign count_o = count_q;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush_i) begin
      fetch_pc_d = flush_pc_i;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (push) fetch_pc_d = fetch_pc_q + 8'd1;
      if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({wr_en, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      fetch_pc_q <= RESET_PC;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  assign wdata = '{pc: fetch_pc_q, instr: mem_data_i};

  core_ifq_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk_i   (clk_i),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (wdata),
    .raddr_i (rd_ptr_q),
    .rdata_o (head)
  );

endmodule

// File: tb/tb_core_ifq.sv
// Scoreboard bench for core_ifq (DEPTH=4, RESET_PC=8'h10).
module tb_core_ifq;
  import core_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic        exec_i;
  logic        flush_i;
  logic [7:0]  flush_pc_i;
  logic        mem_val_o;
  logic [7:0]  mem_addr_o;
  logic        mem_rdy_i;
  logic [15:0] mem_data_i;
  logic        out_val_o;
  logic        out_rdy_i;
  logic [7:0]  out_pc_o;
  logic [15:0] out_instr_o;
  logic [2:0]  count_o;

  int n_tests = 0;
  int n_fail  = 0;

  ifq_entry_t sb[$];
  logic [7:0] m_pc;

  core_ifq #(
    .DEPTH(4),
    .RESET_PC(8'h10)
  ) dut (
    .clk_i       (clk_i),
    .arst_i      (arst_i),
    .exec_i      (exec_i),
    .flush_i     (flush_i),
    .flush_pc_i  (flush_pc_i),
    .mem_val_o   (mem_val_o),
    .mem_addr_o  (mem_addr_o),
    .mem_rdy_i   (mem_rdy_i),
    .mem_data_i  (mem_data_i),
    .out_val_o   (out_val_o),
    .out_rdy_i   (out_rdy_i),
    .out_pc_o    (out_pc_o),
    .out_instr_o (out_instr_o),
    .count_o     (count_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [15:0] instr_of(input logic [7:0] a);
    return {a ^ 8'h5A, ~a};
  endfunction

  assign mem_data_i = instr_of(mem_addr_o);

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    bit hs;
    bit ev;
    int sz;
    ifq_entry_t e;
    @(negedge clk_i);
    sz = sb.size();
    hs = exec_i && !flush_i && (sz < 4) && mem_rdy_i;
`ifdef CORE_IFQ_BYPASS_EN
    ev = !flush_i && (sz != 0 || hs);
`else
    ev = !flush_i && (sz != 0);
`endif
    check("count", 32'(count_o), 32'(sz));
    check("mem_addr", 32'(mem_addr_o), 32'(m_pc));
    check("mem_val", 32'(mem_val_o),
          32'(exec_i && !flush_i && (sz < 4)));
    check("out_val", 32'(out_val_o), 32'(ev));
    if (!ev && sz == 0) begin
      check("empty_pc", 32'(out_pc_o), 32'h0);
      check("empty_instr", 32'(out_instr_o), 32'h0);
    end
    if (flush_i) begin
      sb.delete();
      m_pc = flush_pc_i;
    end else begin
      if (hs) begin
        sb.push_back('{pc: m_pc, instr: instr_of(m_pc)});
        m_pc = m_pc + 8'd1;
      end
      if (ev) begin
        check("head_pc", 32'(out_pc_o), 32'(sb[0].pc));
        check("head_instr", 32'(out_instr_o), 32'(sb[0].instr));
        if (out_rdy_i) e = sb.pop_front();
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    exec_i    = 1'b0;
    flush_i   = 1'b0;
    mem_rdy_i = 1'b0;
    out_rdy_i = 1'b0;
  endtask

  task automatic do_flush(input logic [7:0] pc);
    idle_inputs();
    flush_i    = 1'b1;
    flush_pc_i = pc;
    tick();
    flush_i = 1'b0;
  endtask

  initial begin
    arst_i     = 1'b1;
    flush_pc_i = 8'h00;
    idle_inputs();
    m_pc = 8'h10;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_out_val", 32'(out_val_o), 32'h0);
    check("rst_mem_val", 32'(mem_val_o), 32'h0);
    check("rst_out_pc", 32'(out_pc_o), 32'h0);
    check("rst_out_instr", 32'(out_instr_o), 32'h0);
    check("rst_count", 32'(count_o), 32'h0);
    check("rst_addr", 32'(mem_addr_o), 32'h10);
    arst_i = 1'b0;

    // fill to full: 10..13
    exec_i    = 1'b1;
    mem_rdy_i = 1'b1;
    repeat (6) tick();
    check("fill_count", 32'(count_o), 32'h4);
    check("fill_head", 32'(out_pc_o), 32'h10);

    // drain in order
    exec_i    = 1'b0;
    out_rdy_i = 1'b1;
    repeat (5) tick();
    check("drain_val", 32'(out_val_o), 32'h0);

    // steady state push+pop
    exec_i = 1'b1;
    repeat (8) tick();

    // flush with three queued entries
    do_flush(8'h20);
    exec_i    = 1'b1;
    mem_rdy_i = 1'b1;
    repeat (3) tick();
    check("pre_flush_count", 32'(count_o), 32'h3);
    do_flush(8'h40);
    exec_i    = 1'b1;
    mem_rdy_i = 1'b1;
    out_rdy_i = 1'b1;
    repeat (4) tick();

    // 8-bit PC wrap
    do_flush(8'hFE);
    exec_i    = 1'b1;
    mem_rdy_i = 1'b1;
    repeat (3) tick();
    exec_i    = 1'b0;
    out_rdy_i = 1'b1;
    repeat (4) tick();

    // mem_rdy 1-0-1 -> two pushes
    do_flush(8'h60);
    exec_i    = 1'b1;
    mem_rdy_i = 1'b1;
    tick();
    mem_rdy_i = 1'b0;
    tick();
    mem_rdy_i = 1'b1;
    tick();
    exec_i = 1'b0;
    check("toggle_count", 32'(count_o), 32'h2);
    out_rdy_i = 1'b1;
    repeat (3) tick();

    // empty queue, both sides ready
    exec_i    = 1'b1;
    mem_rdy_i = 1'b1;
    out_rdy_i = 1'b1;
    tick();
    tick();

    // reset mid-operation
    out_rdy_i = 1'b0;
    repeat (2) tick();
    arst_i = 1'b1;
    #2;
    check("mid_rst_count", 32'(count_o), 32'h0);
    check("mid_rst_val", 32'(out_val_o), 32'h0);
    check("mid_rst_mem_val", 32'(mem_val_o), 32'h0);
    check("mid_rst_addr", 32'(mem_addr_o), 32'h10);
    sb.delete();
    m_pc = 8'h10;
    @(posedge clk_i);
    #1;
    arst_i = 1'b0;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      exec_i     = ($urandom_range(0, 3) != 0);
      mem_rdy_i  = ($urandom_range(0, 2) != 0);
      out_rdy_i  = ($urandom_range(0, 2) != 0);
      flush_i    = ($urandom_range(0, 15) == 0);
      flush_pc_i = 8'($urandom_range(0, 255));
      tick();
    end

    idle_inputs();
    out_rdy_i = 1'b1;
    repeat (6) tick();
    check("final_empty", 32'(count_o), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/core_ifq.md
Name: core_ifq

Overview:
Instruction fetch queue between the instruction-memory read port and the decode/execute (dx) stage of the TOY core.
- Generates sequential fetch addresses and issues reads when there is room.
- Buffers returned {pc, instr} pairs in a small FIFO and presents them to dx over a val/rdy handshake.
- A redirect (jump or manual PC write) flushes the queue and restarts fetch at a new PC.

Parameters:
- DEPTH, 4, queue entries; power of two, >= 2.
- RESET_PC, 8'h10, fetch PC after reset.

Ports:
- clk_i  input  1  clock; everything is on the rising edge.
- arst_i  input  1  reset, asynchronous, active-high.
- exec_i  input  1  fetch enable; no new reads are issued while low.
- flush_i  input  1  redirect; empties the queue and reloads the fetch PC.
- flush_pc_i  input  8  new fetch PC, sampled when flush_i=1.
- mem_val_o  output  1  read request valid.
- mem_addr_o  output  8  read address (current fetch PC).
- mem_rdy_i  input  1  memory accepts the request; data is valid in the same cycle.
- mem_data_i  input  16  instruction word, valid when mem_val_o && mem_rdy_i.
- out_val_o  output  1  head entry valid to dx.
- out_rdy_i  input  1  dx consumes the head entry.
- out_pc_o  output  8  PC of the head entry.
- out_instr_o  output  16  instruction of the head entry.
- count_o  output  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (arst_i=1, asynchronous):
  - fetch_pc=RESET_PC, rd/wr pointers=0, count=0.
  - out_val_o=0, mem_val_o=0, out_pc_o=0, out_instr_o=0, count_o=0.
  - Entry storage need not be reset.
- Request:
  - mem_val_o = exec_i && ~flush_i && (count < DEPTH).
  - A pending pop does not create space in the same cycle; there is no pop-credit path.
  - mem_addr_o = fetch_pc at all times.
- Push (mem_val_o && mem_rdy_i):
  - Write {fetch_pc, mem_data_i} at wr_ptr.
  - Increment wr_ptr (mod DEPTH).
  - fetch_pc <= fetch_pc + 1, 8-bit wrap (8'hFF -> 8'h00).
- Pop (out_val_o && out_rdy_i): increment rd_ptr (mod DEPTH).
- Output:
  - out_val_o = (count != 0) && ~flush_i.
  - out_pc_o / out_instr_o come from the entry at rd_ptr; they are 0 when count=0.
  - Minimum latency from memory handshake to out_val_o is 1 cycle.
- Count: push and pop in the same cycle leave count unchanged; otherwise count is +1 on push, -1 on pop.
- Flush (highest priority):
  - No push and no pop occur in the flush cycle.
  - Next cycle: pointers=0, count=0, fetch_pc=flush_pc_i.
  - Fetch resumes the cycle after the flush if exec_i=1.
- exec_i=0: requests stop. Queued entries keep draining to dx, and fetch_pc holds.
- Full (count=DEPTH): mem_val_o=0; fetch_pc holds.
- Empty: out_val_o=0; out_rdy_i is ignored.
- Reset asserted mid-operation discards in-flight state. The memory handshake completes in the same cycle, so no read can be outstanding across reset.

Optional Feature:
- Macro: CORE_IFQ_BYPASS_EN.
- Defined:
  - When count=0, a push occurs, and flush_i=0, the memory data is forwarded combinationally in the same cycle: out_val_o=1, out_pc_o=fetch_pc, out_instr_o=mem_data_i.
  - If out_rdy_i=1 in that cycle, the entry is consumed and not written (count stays 0).
  - Otherwise it is written as a normal push.
- Undefined: no bypass path; minimum latency is 1 cycle.

Decomposition:
- core_pkg holds:
  - typedef ifq_entry_t {pc[7:0], instr[15:0]};
  - constant CORE_RESET_PC=8'h10.
- One sub-module, core_ifq_storage: DEPTH x ifq_entry_t register array with one write port and one asynchronous read port.
- Pointer, count and fetch-PC logic stay in core_ifq.

Test Plan:
- Reset then exec_i=1, mem_rdy_i=1, out_rdy_i=0, DEPTH=4:
  - Requests go to addresses 10,11,12,13.
  - mem_val_o falls after the 4th push; count_o=4.
  - Head is pc=10.
- Drain with out_rdy_i=1, exec_i=0:
  - Entries come out in order 10..13, one per cycle.
  - out_val_o falls after pc=13.
- Steady state with mem_rdy_i=1, out_rdy_i=1, exec_i=1:
  - count_o stays at 1 with simultaneous push and pop every cycle.
  - PCs emerge consecutively.
- Flush with count=3, flush_pc_i=8'h40:
  - out_val_o=0 and mem_val_o=0 in the flush cycle.
  - Next cycle: count_o=0, mem_addr_o=40.
  - First entry out has pc=40.
- Wrap: flush to 8'hFE, fetch three words → queued PCs FE, FF, 00.
- mem_rdy_i toggling 1-0-1 with out_rdy_i=0 → exactly 2 pushes and count_o=2.
- With CORE_IFQ_BYPASS_EN, queue empty, mem_rdy_i=1 and out_rdy_i=1 → out_val_o=1 in the handshake cycle with out_instr_o=mem_data_i, and count_o stays 0.
